md_unit: RTL and testbench

Multi-cycle multiply/divide unit in the E stage, owning the HI/LO register pair. Accepts one MULT/DIV-class operation per start pulse and holds `busy` for a fixed latency. Raises `md_stall` toward the hazard unit so that a following HI/LO-dependent instruction in D stalls. That stall reaches the PC/D-enable/E-clear controller as its `stall` input.

---
 rtl/md_unit_pkg.sv | 54 +++++
 rtl/md_counter.sv | 28 ++
 rtl/md_unit.sv | 128 ++++++++++++
 tb/tb_md_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: op encodings, state type, HI/LO payload and op-class decode
// shared by the multiply/divide unit and the hazard logic.
// Build option: MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
package md_unit_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned XLEN = 32;

  typedef enum logic [OP_W-1:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } hilo_t;

`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  // Accumulate-class ops; only meaningful when the feature is built in.
  function automatic logic is_madd_op(input logic [OP_W-1:0] op);
    return MADD_EN && (op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU});
  endfunction

  // Ops that run for the multiply latency.
  function automatic logic is_mul_op(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || is_madd_op(op);
  endfunction

  // Ops that run for the divide latency.
  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_counter.sv
// md_counter: loadable down-counter that parks at zero; done_c flags the
// final cycle of a run (count == 1).
module md_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done_c
);

  logic [W-1:0] count;

  // Load on accept, otherwise count down to zero and hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done_c = (count == W'(1));

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning HI/LO. Results are computed
// at accept into pending registers and committed after a fixed latency.
// Build option: MDU_MADD_EN (see md_unit_pkg) enables ops 7-10.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        cancel,
  input  logic        md_in_d,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e  state;
  hilo_t      pend;
  logic       pend_we;
  logic       mul_op;
  logic       div_op;
  logic       accept_long;
  logic       cnt_done_c;
  logic [CNT_W-1:0] cnt_load_val;
  hilo_t      mul_res;
  hilo_t      div_res;

  assign mul_op       = is_mul_op(op);
  assign div_op       = is_div_op(op);
  assign accept_long  = (state == ST_IDLE) & start & ~cancel & (mul_op | div_op);
  assign cnt_load_val = mul_op ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
  assign busy         = (state == ST_RUN);
  assign md_stall     = md_in_d & (busy | (start & ~cancel & (mul_op | div_op)));

  md_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (accept_long),
    .load_val (cnt_load_val),
    .done_c   (cnt_done_c)
  );

  // Multiply / accumulate result from current operands and HI/LO.
  always_comb begin
    logic [63:0] a_s, b_s, prod_s, prod_u, acc;
    a_s    = {{32{A[31]}}, A};
    b_s    = {{32{B[31]}}, B};
    prod_s = a_s * b_s;
    prod_u = {32'b0, A} * {32'b0, B};
    acc    = {HI, LO};
    mul_res = hilo_t'(prod_s);
    case (op)
      OP_MULTU: mul_res = hilo_t'(prod_u);
      OP_MADD:  mul_res = hilo_t'(acc + prod_s);
      OP_MADDU: mul_res = hilo_t'(acc + prod_u);
      OP_MSUB:  mul_res = hilo_t'(acc - prod_s);
      OP_MSUBU: mul_res = hilo_t'(acc - prod_u);
      default:  mul_res = hilo_t'(prod_s);
    endcase
  end

  // Divide via magnitudes so INT_MIN / -1 wraps cleanly; quotient to LO, remainder to HI.
  always_comb begin
    logic [31:0] ua, ub, uq, ur;
    ua = A[31] ? -A : A;
    ub = B[31] ? -B : B;
    uq = (ub == '0) ? '0 : ua / ub;
    ur = (ub == '0) ? '0 : ua % ub;
    div_res.lo = (A[31] ^ B[31]) ? -uq : uq;
    div_res.hi = A[31] ? -ur : ur;
    if (op == OP_DIVU) begin
      div_res.lo = (B == '0) ? '0 : A / B;
      div_res.hi = (B == '0) ? '0 : A % B;
    end
  end

  // Control FSM, pending results and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      pend    <= '0;
      pend_we <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !cancel) begin
            if (mul_op) begin
              pend    <= mul_res;
              pend_we <= 1'b1;
              state   <= ST_RUN;
            end else if (div_op) begin
              pend    <= div_res;
              pend_we <= (B != '0);
              state   <= ST_RUN;
            end else if (op == OP_MTHI) begin
              HI <= A;
            end else if (op == OP_MTLO) begin
              LO <= A;
            end
          end
        end
        ST_RUN: begin
          if (cnt_done_c) begin
            if (pend_we) begin
              HI <= pend.hi;
              LO <= pend.lo;
            end
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed scoreboard bench for md_unit.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        cancel;
  logic        md_in_d;
  logic        busy;
  logic        md_stall;
  logic [31:0] HI;
  logic [31:0] LO;

  int unsigned tests;
  int unsigned fails;
  logic [63:0] sb[$];

  md_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .cancel   (cancel),
    .md_in_d  (md_in_d),
    .busy     (busy),
    .md_stall (md_stall),
    .HI       (HI),
    .LO       (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle op (MTHI/MTLO/NONE or cancelled start).
  task automatic issue_short(input logic [3:0] o, input logic [31:0] a, input logic c);
    check("idle_before_short", 32'(busy), 32'd0);
    op = o; A = a; B = 32'd0; cancel = c; start = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0; op = 4'd0;
  endtask

  // Long op: expect N busy cycles, stall tracking md_in_d, then scoreboard HI/LO.
  task automatic run_long(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [31:0] ehi,
                          input logic [31:0] elo, input logic din, input logic cancel_mid);
    logic [63:0] exp;
    check({tag, "_idle_before"}, 32'(busy), 32'd0);
    sb.push_back({ehi, elo});
    op = o; A = a; B = b; cancel = 1'b0; md_in_d = din; start = 1'b1;
    #1;
    check({tag, "_stall_at_start"}, 32'(md_stall), 32'(din));
    tick();
    start = 1'b0; op = 4'd0;
    for (int i = 0; i < n; i++) begin
      cancel = cancel_mid;
      #1;
      check({tag, "_busy_high"}, 32'(busy), 32'd1);
      check({tag, "_stall_busy"}, 32'(md_stall), 32'(din));
      tick();
    end
    cancel = 1'b0;
    #1;
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_stall_low"}, 32'(md_stall), 32'd0);
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      exp = sb.pop_front();
      check({tag, "_hi"}, HI, exp[63:32]);
      check({tag, "_lo"}, LO, exp[31:0]);
    end
    md_in_d = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1; start = 1'b0; op = 4'd0; A = '0; B = '0; cancel = 1'b0; md_in_d = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_stall", 32'(md_stall), 32'd0);
    md_in_d = 1'b0;
    tick();

    run_long("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0);
    run_long("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_long("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1'b0);
    run_long("div_negb", 4'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_long("divu", 4'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3, 1'b0, 1'b0);
    run_long("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, 1'b0, 1'b0);

    // Preload HI/LO, then divide by zero must leave them intact.
    issue_short(4'd5, 32'h11, 1'b0);
    check("mthi_hi", HI, 32'h11);
    issue_short(4'd6, 32'h22, 1'b0);
    check("mtlo_lo", LO, 32'h22);
    check("mtlo_hi_kept", HI, 32'h11);
    run_long("div_zero", 4'd3, 32'd1234, 32'd0, 10, 32'h11, 32'h22, 1'b1, 1'b0);

    // Cancelled start: no stall, no busy, no change.
    md_in_d = 1'b1;
    op = 4'd1; A = 32'd9; B = 32'd9; cancel = 1'b1; start = 1'b1;
    #1;
    check("cancel_stall", 32'(md_stall), 32'd0);
    tick();
    start = 1'b0; cancel = 1'b0; op = 4'd0; md_in_d = 1'b0;
    check("cancel_busy", 32'(busy), 32'd0);
    tick(); tick();
    check("cancel_busy_later", 32'(busy), 32'd0);
    check("cancel_hi", HI, 32'h11);
    check("cancel_lo", LO, 32'h22);

    // Cancel while in RUN does not abort.
    run_long("mult_cancel_run", 4'd1, 32'd3, 32'd4, 5, 32'd0, 32'd12, 1'b1, 1'b1);

    // Reset during cycle 3 of a DIV discards it.
    check("rstmid_idle_before", 32'(busy), 32'd0);
    op = 4'd3; A = 32'd100; B = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; op = 4'd0;
    check("rstmid_busy1", 32'(busy), 32'd1);
    tick();
    tick();
    check("rstmid_busy3", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_hi", HI, 32'd0);
    check("rstmid_lo", LO, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    check("rstmid_busy_after", 32'(busy), 32'd0);
    check("rstmid_hi_after", HI, 32'd0);
    check("rstmid_lo_after", LO, 32'd0);

    // Accumulate ops: HI=0, LO=5, then MADD 3x4.
    issue_short(4'd5, 32'd0, 1'b0);
    issue_short(4'd6, 32'd5, 1'b0);
    check("madd_pre_lo", LO, 32'd5);
`ifdef MDU_MADD_EN
    run_long("madd", 4'd7, 32'd3, 32'd4, 5, 32'd0, 32'd17, 1'b1, 1'b0);
    run_long("msub", 4'd9, 32'd2, 32'd10, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
`else
    md_in_d = 1'b1;
    op = 4'd7; A = 32'd3; B = 32'd4; start = 1'b1;
    #1;
    check("madd_off_stall", 32'(md_stall), 32'd0);
    tick();
    start = 1'b0; op = 4'd0; md_in_d = 1'b0;
    check("madd_off_busy", 32'(busy), 32'd0);
    check("madd_off_hi", HI, 32'd0);
    check("madd_off_lo", LO, 32'd5);
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
